// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DMEM_DEPTH = 1280;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef logic req_id_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant, one-hot output
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_id_t            last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // a lone requester wins outright; on contention the one not granted last time wins
  always_comb
    grant_o = (&valid_i) ? id_onehot(~last_grant_i) : valid_i;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (0) and the debug/loader port (1)
// Optional feature: define DMEM_ARB_BOUNDS_CHECK_EN to answer out-of-range requests with rsp_err
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [ADDR_W-1:0]         mem_address_o,
  output logic [DATA_W-1:0]         mem_write_data_o,
  output logic                      mem_write_o,
  output logic                      mem_read_o,
  input  logic [DATA_W-1:0]         mem_read_data_i
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  req_id_t             last_grant_q, id_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [NUM_REQ-1:0]  grant;
  req_id_t             win;
  logic                accept, oor;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  rr_arb2 u_arb (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // winner selection and acceptance; acceptance only happens while idle
  always_comb begin
    win       = grant[1];
    win_addr  = win ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    win_wdata = win ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
    accept    = (state_q == IDLE) && |grant;
    oor       = BOUNDS_EN && (win_addr >= ADDR_W'(DEPTH));
  end

  // state register; reset drops any in-flight transaction and kills the strobes at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: out-of-range requests skip the memory access entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (oor ? RESP : ACCESS) : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = rsp_ready_i[id_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state; strobes exist only during the single ACCESS cycle
  always_comb begin
    req_ready_o = (state_q == IDLE) ? grant : '0;
    mem_write_o = (state_q == ACCESS) && we_q;
    mem_read_o  = (state_q == ACCESS) && !we_q;
    rsp_valid_o = (state_q == RESP) ? id_onehot(id_q) : '0;
  end

  // request latch at acceptance and response capture at the end of ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else if (accept) begin
      last_grant_q <= win;
      id_q         <= win;
      we_q         <= req_we_i[win];
      addr_q       <= win_addr;
      wdata_q      <= win_wdata;
      if (oor) rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      rdata_q      <= we_q ? '0 : mem_read_data_i;
    end
  end

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  logic err_q;

  // error flag is decided at acceptance and held through the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= oor;
  end

  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign mem_address_o    = addr_q;
  assign mem_write_data_o = wdata_q;
  assign rsp_rdata_o      = rdata_q;

endmodule
